// File: rtl/vga_fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_pkg
// Purpose  : Shared timing constants, widths and fetch-state encoding for the
//            edge frame-buffer scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package vga_fb_pkg;

  localparam int WORD_W   = 16;
  localparam int H_ACTIVE = 640;
  localparam int WPL      = H_ACTIVE / WORD_W;
  localparam int ADDR_W   = 15;
  localparam int HV_W     = 10;

  localparam logic [HV_W-1:0] HBP         = 10'd144;
  localparam logic [HV_W-1:0] HFP         = 10'd784;
  localparam logic [HV_W-1:0] VBP         = 10'd31;
  localparam logic [HV_W-1:0] VFP         = 10'd511;
  localparam logic [HV_W-1:0] VLINES      = 10'd521;
  localparam logic [HV_W-1:0] FETCH_START = 10'd784;

  localparam int BIT_W  = $clog2(WORD_W);
  localparam int PIX_W  = $clog2(H_ACTIVE);
  localparam int WIDX_W = PIX_W - BIT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // First RAM word of a display row.
  function automatic logic [ADDR_W-1:0] row_base(input logic [HV_W-1:0] row);
    return ADDR_W'(row) * ADDR_W'(WPL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : vga_line_buffer
// Purpose  : Two-bank ping-pong store of one display line each; word-wide
//            write from the RAM fetch, bit-wide read for the pixel path.
// Revision : 1.0 - initial release
// ============================================================================
module vga_line_buffer
  import vga_fb_pkg::*;
(
  input  logic              dclk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [WIDX_W-1:0] wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [PIX_W-1:0]  rd_pix,
  output logic              rd_bit
);

  logic [WIDX_W-1:0] w_rd_word;
  logic [BIT_W-1:0]  w_rd_sel;
  logic [1:0]        w_bank_bit;

  assign w_rd_word = rd_pix[PIX_W-1:BIT_W];
  assign w_rd_sel  = rd_pix[BIT_W-1:0];

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      logic [WORD_W-1:0] r_words [WPL];

      always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
          for (int i = 0; i < WPL; i++) begin
            r_words[i] <= '0;
          end
        end else if (wr_en && (wr_bank == 1'(b)) && (wr_idx < WIDX_W'(WPL))) begin
          r_words[wr_idx] <= wr_data;
        end
      end

      // Pixel indices past the line end read as black.
      assign w_bank_bit[b] = (w_rd_word < WIDX_W'(WPL)) ? r_words[w_rd_word][w_rd_sel] : 1'b0;
    end
  endgenerate

  assign rd_bit = w_bank_bit[rd_bank];

endmodule
`default_nettype wire

// File: rtl/vga_fb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_scheduler
// Purpose  : Arbitrates the single-port edge frame buffer between the edge
//            writer and a per-line burst fetch feeding the VGA pixel path.
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_scheduler
  import vga_fb_pkg::*;
(
  input  logic              dclk,
  input  logic              clr,
  input  logic [HV_W-1:0]   hc,
  input  logic [HV_W-1:0]   vc,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              pix_on,
  output logic              fetch_busy
);

  localparam logic [HV_W-1:0]   c_vtrig_lo  = VBP - HV_W'(1);
  localparam logic [HV_W-1:0]   c_vtrig_hi  = VFP - HV_W'(1);
  localparam logic [HV_W-1:0]   c_vlast     = VLINES - HV_W'(1);
  localparam logic [WIDX_W-1:0] c_last_word = WIDX_W'(WPL - 1);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [WIDX_W-1:0] r_k;
  logic [ADDR_W-1:0] r_base;
  logic              r_bank;
  logic              r_cap_vld;
  logic [WIDX_W-1:0] r_cap_idx;
  logic              r_pix_on;

  logic              w_trigger;
  logic [HV_W-1:0]   w_row;
  logic              w_active;
  logic [HV_W-1:0]   w_hoff;
  logic              w_disp_bank;
  logic              w_buf_bit;

  // vc is the line before the one being fetched.
  assign w_row     = vc - c_vtrig_lo;
  assign w_trigger = (r_state == IDLE) && (hc == FETCH_START) &&
                     (vc >= c_vtrig_lo) && (vc < c_vtrig_hi) && (vc != c_vlast);

  assign w_active    = (vc >= VBP) && (vc < VFP) && (hc >= HBP) && (hc < HFP);
  assign w_hoff      = hc - HBP;
  // Parity of (vc - VBP) without a subtractor.
  assign w_disp_bank = vc[0] ^ VBP[0];

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_base    <= '0;
      r_bank    <= 1'b0;
      r_cap_vld <= 1'b0;
      r_cap_idx <= '0;
      r_pix_on  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_trigger) begin
        r_base <= row_base(w_row);
        r_bank <= w_row[0];
        r_k    <= '0;
      end else if (r_state == FETCH) begin
        r_k <= r_k + WIDX_W'(1);
      end
      // Read data returns one cycle after the address.
      r_cap_vld <= (r_state == FETCH);
      r_cap_idx <= r_k;
      r_pix_on  <= w_active ? w_buf_bit : 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    wr_ready    = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (r_state)
      IDLE: begin
        wr_ready = !w_trigger;
        if (w_trigger) begin
          w_state_nxt = FETCH;
        end else if (wr_valid) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = wr_addr;
          mem_wdata = wr_data;
        end
      end
      FETCH: begin
        mem_en   = 1'b1;
        mem_addr = r_base + ADDR_W'(r_k);
        if (r_k == c_last_word) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  vga_line_buffer u_line_buffer (
    .dclk    (dclk),
    .clr     (clr),
    .wr_en   (r_cap_vld),
    .wr_bank (r_bank),
    .wr_idx  (r_cap_idx),
    .wr_data (mem_rdata),
    .rd_bank (w_disp_bank),
    .rd_pix  (w_hoff[PIX_W-1:0]),
    .rd_bit  (w_buf_bit)
  );

  assign pix_on     = r_pix_on;
  assign fetch_busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/vga_fb_scheduler.md
Name: vga_fb_scheduler

Overview:
- Owns the single-port 1-bit edge frame buffer RAM and schedules its two users:
  - the edge-detector result writer (valid/ready handshake);
  - the VGA display path.
- During horizontal blanking, bursts the next active line into a ping-pong line buffer. During active video, serves pixels from that buffer.
- Sits between the edge detector, the frame buffer RAM and the 640x480 VGA timing generator. Takes hc/vc from the timing generator.

Parameters:
WORD_W, 16, pixels per RAM word; pixel x at bit x%WORD_W (LSB = leftmost)
H_ACTIVE, 640, active pixels per line
HBP, 144, first active hc
HFP, 784, first hc after active video
VBP, 31, first active vc
VFP, 511, first vc after active video
VLINES, 521, lines per frame
FETCH_START, 784, hc at which the line fetch is triggered
ADDR_W, 15, RAM word address width
(localparam WPL = H_ACTIVE/WORD_W = 40 words per line)

Ports:
dclk  in  1  pixel clock, 25 MHz
clr  in  1  reset, asynchronous, active-high
hc  in  10  horizontal counter from timing generator
vc  in  10  vertical counter from timing generator
wr_valid  in  1  edge writer has a word
wr_ready  out  1  scheduler accepts the word this cycle
wr_addr  in  ADDR_W  word address (row*WPL + x/WORD_W)
wr_data  in  WORD_W  pixel word
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  WORD_W  RAM write data
mem_rdata  in  WORD_W  RAM read data; valid the cycle after a read
pix_on  out  1  registered pixel: 1 = edge (white), 0 = black
fetch_busy  out  1  line fetch in progress (FETCH or DRAIN)

Behaviour:
- Reset (clr=1, async):
  - state=IDLE; both line-buffer banks cleared to 0.
  - pix_on=0, fetch_busy=0, mem_en=0, mem_we=0.
  - mem_addr=0, mem_wdata=0; word counter=0.
- Trigger:
  - Fires when state==IDLE, hc==FETCH_START, and (vc+1) is in [VBP,VFP).
  - Target row r = vc+1-VBP; no fetch at vc=VFP-1 or vc=VLINES-1 (wrap).
  - Latch base = r*WPL (shift-add allowed) and bank = r[0].
- States:
  - IDLE -> FETCH on trigger.
  - FETCH: k = 0..WPL-1; each cycle drives mem_en=1, mem_we=0, mem_addr=base+k. After k=WPL-1 -> DRAIN.
  - DRAIN: one cycle capturing the last word, then -> IDLE.
- Read capture:
  - Data for read k is captured on the following cycle into linebuf[bank][k*WORD_W +: WORD_W].
  - The fetch completes in WPL+1 = 41 cycles after the trigger edge (hc 785..825).
- Write path:
  - wr_ready = (state==IDLE) && !trigger, combinational.
  - On wr_valid && wr_ready, the same cycle drives mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data. The transfer completes that cycle.
  - Writer holds wr_valid/addr/data stable until accepted. No data loss.
- Simultaneous trigger and wr_valid: fetch wins; the write is stalled and accepted on the first IDLE cycle (hc=826).
- Display:
  - Active region is vc in [VBP,VFP) && hc in [HBP,HFP).
  - pix_on <= active ? linebuf[(vc-VBP)[0]][hc-HBP] : 0.
  - Latency is 1 cycle; the timing generator delays hsync/vsync by 1 to match.
- Bank usage: the fetch writes bank r[0] while display rows use bank (r-1)[0]. No bank conflict.
- Reset mid-fetch: the fetch is abandoned. IDLE, banks cleared, mem_en=0 on reset assertion.
- mem_en=0 in IDLE when no write is accepted.
- fetch_busy is registered-state based and equals 1 exactly in FETCH/DRAIN.

Decomposition:
- Package vga_fb_pkg holds:
  - timing constants (HBP, HFP, VBP, VFP, VLINES, H_ACTIVE);
  - WORD_W, WPL, ADDR_W;
  - the state enum {IDLE, FETCH, DRAIN}.
- One natural sub-module: vga_line_buffer, the 2 x H_ACTIVE ping-pong store.
  - Write port: word-wide, bank/word index.
  - Read port: bit-wide, bank/pixel index.
  - Async clear on clr.

Test Plan:
1. Reset with clr=1 mid-frame -> pix_on=0, mem_en=0, fetch_busy=0. After release in IDLE away from trigger -> wr_ready=1.
2. Write wr_addr=40, wr_data=16'h0001 (row 1, x=0).
   - Required: mem_we=1 with mem_addr=40 the same cycle.
   - pix_on=1 the cycle after vc=32/hc=144; pix_on=0 after hc=145.
3. At vc=30, hc=784:
   - mem_en/!mem_we with mem_addr 0..39 on hc 785..824.
   - fetch_busy=1 for hc 785..825; wr_ready=0 for hc 784..825.
4. Hold wr_valid=1 (addr 100, data 16'hFFFF) from hc=780 on a fetch line:
   - If accepted at hc 780..783, done at once.
   - Else held through 784..825 and accepted at hc=826. RAM readback = 16'hFFFF.
5. vc=510 and vc=520 at hc=784 -> no fetch, mem_en stays 0, wr_ready stays 1.
6. Assert clr during the 20th fetch read -> state IDLE immediately, mem_en=0, pix_on=0. The next frame refetches correctly (row 0 pixels match the RAM).
